// File: rtl/dmem_lsu_if.sv
// Request/response bus of the data-memory load/store unit.
// The core drives through the master modport; dmem_lsu takes the slave side.
interface dmem_lsu_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic               i_req_we;
    logic [2:0]         i_req_funct3;
    logic [NB_ADDR-1:0] i_req_addr;
    logic [NB_DATA-1:0] i_req_wdata;
    logic               o_rsp_valid;
    logic               i_rsp_ready;
    logic [NB_DATA-1:0] o_rsp_rdata;
    logic               o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
    modport slave (
        input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with RISC-V sub-word loads/stores and wait states.
// DMEM_LSU_MISALIGN_TRAP_EN: misaligned H/W/D accesses become errors instead of aligning down.
module dmem_lsu #(
    parameter int NB_DATA     = 32,
    parameter int NB_ADDR     = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 1
) (
    input logic       i_clock,
    input logic       i_rst_n,
    dmem_lsu_if.slave bus
);
    localparam int NBYTES = NB_DATA / 8;
    localparam int AW     = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef struct packed {
        logic               we;
        logic [2:0]         funct3;
        logic [NB_ADDR-1:0] addr;
        logic [NB_DATA-1:0] wdata;
    } req_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               mem_we;

    logic [7:0]         mem [MEM_BYTES];

    logic [3:0]         size;
    logic [NB_ADDR-1:0] mask, eff_addr;
    logic [NB_ADDR:0]   end_addr;
    logic               f3_ok, range_err, mis_err, acc_err, sign;
    logic [NB_DATA-1:0] raw, ld_data;

    // Decode of the latched request: size, legality, effective address.
    always_comb begin
        size = 4'd1 << req_q.funct3[1:0];
        mask = NB_ADDR'(size - 4'd1);
        case (req_q.funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_q.we;
            3'b011:                 f3_ok = (NB_DATA == 64);
            3'b110:                 f3_ok = (NB_DATA == 64) && !req_q.we;
            default:                f3_ok = 1'b0;
        endcase
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        eff_addr = req_q.addr;
        mis_err  = |(req_q.addr & mask);
`else
        eff_addr = req_q.addr & ~mask;
        mis_err  = 1'b0;
`endif
        // One extra bit so addresses near the top of the space cannot wrap.
        end_addr  = {1'b0, eff_addr} + (NB_ADDR+1)'(size);
        range_err = end_addr > (NB_ADDR+1)'(MEM_BYTES);
        acc_err   = !f3_ok || range_err || mis_err;
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NBYTES; i++)
            raw[i*8 +: 8] = mem[AW'(eff_addr + NB_ADDR'(i))];
        case (req_q.funct3[1:0])
            2'b00:   sign = raw[7];
            2'b01:   sign = raw[15];
            2'b10:   sign = raw[31];
            default: sign = raw[NB_DATA-1];
        endcase
        ld_data = '0;
        for (int b = 0; b < NB_DATA; b++)
            ld_data[b] = (7'(b) < {size, 3'b000}) ? raw[b] : (!req_q.funct3[2] && sign);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: if (bus.i_req_valid) begin
                req_d   = '{we: bus.i_req_we, funct3: bus.i_req_funct3,
                            addr: bus.i_req_addr, wdata: bus.i_req_wdata};
                cnt_d   = 4'(WAIT_STATES);
                state_d = WAIT;
            end
            WAIT: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                mem_we  = req_q.we && !acc_err;
                rdata_d = (req_q.we || acc_err) ? '0 : ld_data;
                err_d   = acc_err;
                state_d = RESP;
            end
            RESP: if (bus.i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset; mem_we is low whenever state is IDLE.
    always_ff @(posedge i_clock) begin
        if (mem_we)
            for (int i = 0; i < NBYTES; i++)
                if (4'(i) < size)
                    mem[AW'(eff_addr + NB_ADDR'(i))] <= req_q.wdata[i*8 +: 8];
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = (state_q == RESP);
    assign bus.o_rsp_rdata = rdata_q;
    assign bus.o_rsp_err   = err_q;
endmodule
